rdmemory_pipe: RTL and testbench
================================

Name: rdmemory_pipe

Overview:
Parametrised, pipelined read-memory requester. Accepts read addresses from an upstream master and issues them to the memory request channel with up to RESP_DEPTH reads outstanding. Returns read data to a downstream slave in issue order. Sits between a load unit and the memory port. Credit-based issue guarantees a buffer slot for every response, so the memory response channel is never back-pressured.

Parameters:
AW, 16, address width in bits
DW, 32, data width in bits
REQ_DEPTH, 4, request FIFO entries (power of 2, >=2)
RESP_DEPTH, 4, response FIFO entries = max reads in flight plus buffered (power of 2, >=2)

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_master_valid  in  1  read request valid
o_master_ready  out  1  request FIFO not full
i_master_addr  in  AW  read address
o_slave_valid  out  1  read data valid
i_slave_ready  in  1  downstream accepts data
o_slave_data  out  DW  read data
o_mem_req_valid  out  1  memory request valid
i_mem_req_ready  in  1  memory accepts request
o_mem_req_addr  out  AW  memory request address
i_mem_resp_valid  in  1  memory response valid (in order)
o_mem_resp_ready  out  1  response accept, constant 1 out of reset
i_mem_resp_data  in  DW  memory response data
o_inflight  out  $clog2(RESP_DEPTH+1)  requests issued, response not yet received
o_idle  out  1  both FIFOs empty and o_inflight==0

Behaviour:
- Reset (async assert, sync release): FIFOs empty, inflight=0. o_master_ready=1, o_slave_valid=0, o_mem_req_valid=0, o_mem_req_addr=0, o_slave_data=0, o_mem_resp_ready=0 while reset asserted and 1 afterwards, o_idle=1.
- Handshake: a transfer occurs when valid&ready are both high at the clock edge. A valid signal, once high, holds value and payload until accepted.
- Request FIFO: push on master handshake. o_master_ready = !req_full. A push and a pop in the same cycle while full is not allowed, because ready is driven from the registered full flag.
- Credit: resp_used = inflight + resp_cnt. o_mem_req_valid = !req_empty && (resp_used < RESP_DEPTH). o_mem_req_addr = head of the request FIFO.
- Once o_mem_req_valid is raised, it must not drop before acceptance. This holds because credits only increase while waiting.
- inflight: +1 on a memory request handshake, -1 on i_mem_resp_valid, net 0 when both occur in the same cycle.
- A response arriving while inflight==0 is a protocol error. It is ignored, and an assertion fires in simulation.
- Response FIFO: push on i_mem_resp_valid. The credit rule guarantees it never overflows. o_slave_valid = !resp_empty, and o_slave_data = head entry. Pop on slave handshake.
- Latency:
  - Master accepted at edge N → o_mem_req_valid high after edge N, provided credit is available; no bypass.
  - Response at edge M → o_slave_valid after edge M.
  - Minimum round trip excluding memory latency is 2 cycles.
- Throughput: 1 request/cycle and 1 response/cycle sustained when credits are available.
- Ordering: data is delivered strictly in master-request order, with no reordering.
- Boundaries:
  - Req FIFO full: master is stalled.
  - resp_used==RESP_DEPTH: issue stalls, including when the slave is back-pressured.
  - Pointers wrap modulo depth, with count held in an extra bit.
  - Simultaneous push and pop on a non-full/non-empty FIFO: count unchanged.
- Reset mid-operation: all state is cleared immediately. Lost responses are the system's responsibility, and memory must be reset together with this block.

Test Plan:
- Single read: addr 0x0010 accepted; memory returns 0xDEADBEEF 3 cycles after request → o_slave_data=0xDEADBEEF, o_slave_valid high exactly 1 cycle after response; o_idle returns to 1.
- Back-to-back: 8 addresses 0x0000..0x0007 streamed; memory always ready, responses data=addr+0x100 after a fixed latency of 2 → 8 outputs in order 0x100..0x107, no bubbles on mem_req.
- Slave stall: i_slave_ready=0, 6 requests, RESP_DEPTH=4 → exactly 4 mem requests issued, inflight+resp_cnt=4; o_master_ready drops after request FIFO fills; after release, all 6 delivered in order.
- Memory stall: i_mem_req_ready=0 for 10 cycles → o_mem_req_valid held with stable addr; 4 master requests accepted, 5th blocked (o_master_ready=0).
- Simultaneous: same-cycle mem request handshake and response with inflight=2 → inflight stays 2; same-cycle push/pop of response FIFO keeps count.
- Reset mid-stream: assert i_reset_n=0 with inflight=3 → all outputs take reset values asynchronously; after release o_idle=1 and a new read completes correctly.

Source files
------------

// File: rtl/rdmemory_pipe.sv
// Pipelined read-memory requester: in-order reads with credit-limited issue.
// Request and response FIFOs share one parametrised FIFO submodule.
module rdmemory_pipe_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_push,
    input  logic [W-1:0]            i_data,
    input  logic                    i_pop,
    output logic [W-1:0]            o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign o_count = wr_ptr - rd_ptr;
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (o_count == (PW+1)'(DEPTH));
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[PW-1:0]] <= i_data;
                wr_ptr              <= wr_ptr + (PW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

endmodule

module rdmemory_pipe #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int REQ_DEPTH  = 4,
    parameter int RESP_DEPTH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_master_valid,
    output logic                            o_master_ready,
    input  logic [AW-1:0]                   i_master_addr,
    output logic                            o_slave_valid,
    input  logic                            i_slave_ready,
    output logic [DW-1:0]                   o_slave_data,
    output logic                            o_mem_req_valid,
    input  logic                            i_mem_req_ready,
    output logic [AW-1:0]                   o_mem_req_addr,
    input  logic                            i_mem_resp_valid,
    output logic                            o_mem_resp_ready,
    input  logic [DW-1:0]                   i_mem_resp_data,
    output logic [$clog2(RESP_DEPTH+1)-1:0] o_inflight,
    output logic                            o_idle
);

    localparam int CW = $clog2(RESP_DEPTH+1);
    localparam int RW = $clog2(REQ_DEPTH) + 1;
    localparam int SW = $clog2(RESP_DEPTH) + 1;

    logic          req_full;
    logic          req_empty;
    logic [RW-1:0] req_cnt;
    logic          resp_full;
    logic          resp_empty;
    logic [SW-1:0] resp_cnt;
    logic [CW-1:0] inflight;
    logic [CW:0]   resp_used;
    logic          credit_ok;
    logic          master_hs;
    logic          req_hs;
    logic          resp_ok;
    logic          slave_hs;
    logic          resp_ready_q;

    assign master_hs = i_master_valid && o_master_ready;
    assign req_hs    = o_mem_req_valid && i_mem_req_ready;
    assign slave_hs  = o_slave_valid && i_slave_ready;

    // A response with nothing outstanding is dropped, never buffered.
    assign resp_ok = i_mem_resp_valid && resp_ready_q
                     && (inflight != '0) && !resp_full;

    // Every issued read owns a response slot until it is delivered.
    assign resp_used = (CW+1)'(inflight) + (CW+1)'(resp_cnt);
    assign credit_ok = (resp_used < (CW+1)'(RESP_DEPTH));

    rdmemory_pipe_fifo #(
        .W     (AW),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (master_hs),
        .i_data    (i_master_addr),
        .i_pop     (req_hs),
        .o_data    (o_mem_req_addr),
        .o_full    (req_full),
        .o_empty   (req_empty),
        .o_count   (req_cnt)
    );

    rdmemory_pipe_fifo #(
        .W     (DW),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (resp_ok),
        .i_data    (i_mem_resp_data),
        .i_pop     (slave_hs),
        .o_data    (o_slave_data),
        .o_full    (resp_full),
        .o_empty   (resp_empty),
        .o_count   (resp_cnt)
    );

    assign o_master_ready   = !req_full;
    assign o_mem_req_valid  = !req_empty && credit_ok;
    assign o_slave_valid    = !resp_empty;
    assign o_mem_resp_ready = resp_ready_q;
    assign o_inflight       = inflight;
    assign o_idle = (req_cnt == '0) && (resp_cnt == '0)
                    && (inflight == '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            inflight     <= '0;
            resp_ready_q <= 1'b0;
        end else begin
            resp_ready_q <= 1'b1;
            unique case ({req_hs, resp_ok})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    resp_has_owner: assert property (
        @(posedge i_clk) disable iff (!i_reset_n)
        (i_mem_resp_valid && resp_ready_q) |-> (inflight != '0)
    );

endmodule

// File: tb/tb_rdmemory_pipe.sv
// Directed bench for rdmemory_pipe with a fixed-latency memory model.
module tb_rdmemory_pipe;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_master_valid;
    logic        o_master_ready;
    logic [15:0] i_master_addr;
    logic        o_slave_valid;
    logic        i_slave_ready;
    logic [31:0] o_slave_data;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [15:0] o_mem_req_addr;
    logic        i_mem_resp_valid;
    logic        o_mem_resp_ready;
    logic [31:0] i_mem_resp_data;
    logic [2:0]  o_inflight;
    logic        o_idle;

    int vec  = 0;
    int errs = 0;

    logic        auto_mem = 1'b1;
    int          lat      = 2;
    logic [31:0] data_off = 32'h0;
    logic        man_valid = 1'b0;
    logic [31:0] man_data  = 32'h0;
    int          ncyc = 0;
    logic [15:0] q_addr[$];
    int          q_due[$];
    int          hs_cyc[$];
    logic [31:0] got[$];

    always #5 i_clk = ~i_clk;

    rdmemory_pipe dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_master_valid   (i_master_valid),
        .o_master_ready   (o_master_ready),
        .i_master_addr    (i_master_addr),
        .o_slave_valid    (o_slave_valid),
        .i_slave_ready    (i_slave_ready),
        .o_slave_data     (o_slave_data),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_req_addr   (o_mem_req_addr),
        .i_mem_resp_valid (i_mem_resp_valid),
        .o_mem_resp_ready (o_mem_resp_ready),
        .i_mem_resp_data  (i_mem_resp_data),
        .o_inflight       (o_inflight),
        .o_idle           (o_idle)
    );

    // Memory model: decisions at negedge take effect at the next posedge.
    initial begin
        i_mem_resp_valid = 1'b0;
        i_mem_resp_data  = 32'h0;
        forever begin
            @(negedge i_clk);
            ncyc++;
            if (!i_reset_n) begin
                q_addr.delete();
                q_due.delete();
                i_mem_resp_valid = 1'b0;
            end else if (auto_mem) begin
                if (q_due.size() > 0 && q_due[0] <= ncyc) begin
                    i_mem_resp_valid = 1'b1;
                    i_mem_resp_data  = {16'h0, q_addr[0]} + data_off;
                    void'(q_addr.pop_front());
                    void'(q_due.pop_front());
                end else begin
                    i_mem_resp_valid = 1'b0;
                end
                if (o_mem_req_valid && i_mem_req_ready) begin
                    q_addr.push_back(o_mem_req_addr);
                    q_due.push_back(ncyc + lat);
                    hs_cyc.push_back(ncyc);
                end
            end else begin
                i_mem_resp_valid = man_valid;
                i_mem_resp_data  = man_data;
                if (o_mem_req_valid && i_mem_req_ready)
                    hs_cyc.push_back(ncyc);
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (i_reset_n && o_slave_valid && i_slave_ready)
                got.push_back(o_slave_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_req(input logic [15:0] a);
        logic ok;
        ok = 1'b0;
        i_master_valid = 1'b1;
        i_master_addr  = a;
        for (int k = 0; k < 60; k++) begin
            @(negedge i_clk);
            if (o_master_ready) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        i_master_valid = 1'b0;
        vec++;
        if (!ok) begin
            errs++;
            $display("FAIL push_%h: accepted=%0b required=1", a, ok);
        end
    endtask

    task automatic wait_got(input int n, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (got.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        i_reset_n      = 1'b0;
        i_master_valid = 1'b0;
        i_master_addr  = 16'h0;
        i_slave_ready  = 1'b0;
        i_mem_req_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #3;
        vec += 8;
        if (o_master_ready !== 1'b1) begin errs++;
            $display("FAIL rst_mready: got %b want 1", o_master_ready); end
        if (o_slave_valid !== 1'b0) begin errs++;
            $display("FAIL rst_svalid: got %b want 0", o_slave_valid); end
        if (o_mem_req_valid !== 1'b0) begin errs++;
            $display("FAIL rst_reqvalid: got %b want 0", o_mem_req_valid); end
        if (o_mem_req_addr !== 16'h0) begin errs++;
            $display("FAIL rst_addr: got %h want 0", o_mem_req_addr); end
        if (o_slave_data !== 32'h0) begin errs++;
            $display("FAIL rst_sdata: got %h want 0", o_slave_data); end
        if (o_mem_resp_ready !== 1'b0) begin errs++;
            $display("FAIL rst_respready: got %b want 0", o_mem_resp_ready); end
        if (o_idle !== 1'b1) begin errs++;
            $display("FAIL rst_idle: got %b want 1", o_idle); end
        if (o_inflight !== 3'd0) begin errs++;
            $display("FAIL rst_inflight: got %0d want 0", o_inflight); end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        step();
        vec += 2;
        if (o_mem_resp_ready !== 1'b1) begin errs++;
            $display("FAIL rel_respready: got %b want 1", o_mem_resp_ready); end
        if (o_idle !== 1'b1) begin errs++;
            $display("FAIL rel_idle: got %b want 1", o_idle); end
    endtask

    task automatic test_single();
        i_slave_ready   = 1'b1;
        i_mem_req_ready = 1'b1;
        auto_mem = 1'b1;
        lat      = 3;
        data_off = 32'hDEAD_BEDF;
        push_req(16'h0010);
        vec += 2;
        if (o_mem_req_valid !== 1'b1) begin errs++;
            $display("FAIL single_reqvalid: got %b want 1", o_mem_req_valid); end
        if (o_mem_req_addr !== 16'h0010) begin errs++;
            $display("FAIL single_addr: got %h want 0010", o_mem_req_addr); end
        step();
        vec++;
        if (o_inflight !== 3'd1) begin errs++;
            $display("FAIL single_inflight: got %0d want 1", o_inflight); end
        repeat (2) begin
            step();
            vec++;
            if (o_slave_valid !== 1'b0) begin errs++;
                $display("FAIL single_early: got %b want 0", o_slave_valid); end
        end
        step();
        vec += 3;
        if (o_slave_valid !== 1'b1) begin errs++;
            $display("FAIL single_svalid: got %b want 1", o_slave_valid); end
        if (o_slave_data !== 32'hDEAD_BEEF) begin errs++;
            $display("FAIL single_data: got %h want deadbeef", o_slave_data); end
        if (o_inflight !== 3'd0) begin errs++;
            $display("FAIL single_inflight0: got %0d want 0", o_inflight); end
        step();
        vec += 2;
        if (o_slave_valid !== 1'b0) begin errs++;
            $display("FAIL single_svalid_off: got %b want 0", o_slave_valid); end
        if (o_idle !== 1'b1) begin errs++;
            $display("FAIL single_idle: got %b want 1", o_idle); end
    endtask

    task automatic test_back_to_back();
        int   gb;
        int   hb;
        logic ok;
        gb = got.size();
        hb = hs_cyc.size();
        lat      = 2;
        data_off = 32'h100;
        for (int i = 0; i < 8; i++)
            push_req(16'(i));
        wait_got(gb + 8, ok);
        vec++;
        if (!ok) begin errs++;
            $display("FAIL b2b_timeout: got %0d want %0d", got.size() - gb, 8); end
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (got.size() <= gb + i || got[gb+i] !== 32'h100 + 32'(i)) begin
                errs++;
                $display("FAIL b2b_data%0d: got %h want %h", i,
                         (got.size() > gb + i) ? got[gb+i] : 32'hx, 32'h100 + 32'(i));
            end
        end
        vec++;
        if (hs_cyc.size() < hb + 8 || hs_cyc[hb+7] - hs_cyc[hb] != 7) begin
            errs++;
            $display("FAIL b2b_bubbles: handshakes=%0d span=%0d want 8 span 7",
                     hs_cyc.size() - hb,
                     (hs_cyc.size() >= hb + 8) ? hs_cyc[hb+7] - hs_cyc[hb] : -1);
        end
        repeat (3) step();
        vec++;
        if (o_idle !== 1'b1) begin errs++;
            $display("FAIL b2b_idle: got %b want 1", o_idle); end
    endtask

    task automatic test_slave_stall();
        int   gb;
        int   hb;
        logic ok;
        gb = got.size();
        hb = hs_cyc.size();
        data_off = 32'h200;
        i_slave_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            push_req(16'h20 + 16'(i));
        repeat (8) step();
        vec += 6;
        if (hs_cyc.size() - hb != 4) begin errs++;
            $display("FAIL stall_issued: got %0d want 4", hs_cyc.size() - hb); end
        if (o_mem_req_valid !== 1'b0) begin errs++;
            $display("FAIL stall_reqvalid: got %b want 0", o_mem_req_valid); end
        if (o_inflight !== 3'd0) begin errs++;
            $display("FAIL stall_inflight: got %0d want 0", o_inflight); end
        if (o_slave_valid !== 1'b1) begin errs++;
            $display("FAIL stall_svalid: got %b want 1", o_slave_valid); end
        if (o_slave_data !== 32'h220) begin errs++;
            $display("FAIL stall_head: got %h want 220", o_slave_data); end
        if (o_master_ready !== 1'b1) begin errs++;
            $display("FAIL stall_mready2: got %b want 1", o_master_ready); end
        push_req(16'h26);
        push_req(16'h27);
        vec++;
        if (o_master_ready !== 1'b0) begin errs++;
            $display("FAIL stall_mready_full: got %b want 0", o_master_ready); end
        i_slave_ready = 1'b1;
        wait_got(gb + 8, ok);
        vec++;
        if (!ok) begin errs++;
            $display("FAIL stall_timeout: got %0d want 8", got.size() - gb); end
        for (int i = 0; i < 8; i++) begin
            vec++;
            if (got.size() <= gb + i || got[gb+i] !== 32'h220 + 32'(i)) begin
                errs++;
                $display("FAIL stall_data%0d: got %h want %h", i,
                         (got.size() > gb + i) ? got[gb+i] : 32'hx, 32'h220 + 32'(i));
            end
        end
        repeat (3) step();
    endtask

    task automatic test_mem_stall();
        int   gb;
        logic ok;
        gb = got.size();
        data_off = 32'h300;
        i_mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_req(16'h30 + 16'(i));
        i_master_valid = 1'b1;
        i_master_addr  = 16'h34;
        for (int k = 0; k < 10; k++) begin
            step();
            vec += 3;
            if (o_mem_req_valid !== 1'b1) begin errs++;
                $display("FAIL mstall_valid%0d: got %b want 1", k, o_mem_req_valid); end
            if (o_mem_req_addr !== 16'h30) begin errs++;
                $display("FAIL mstall_addr%0d: got %h want 0030", k, o_mem_req_addr); end
            if (o_master_ready !== 1'b0) begin errs++;
                $display("FAIL mstall_mready%0d: got %b want 0", k, o_master_ready); end
        end
        i_mem_req_ready = 1'b1;
        push_req(16'h34);
        wait_got(gb + 5, ok);
        vec++;
        if (!ok) begin errs++;
            $display("FAIL mstall_timeout: got %0d want 5", got.size() - gb); end
        for (int i = 0; i < 5; i++) begin
            vec++;
            if (got.size() <= gb + i || got[gb+i] !== 32'h330 + 32'(i)) begin
                errs++;
                $display("FAIL mstall_data%0d: got %h want %h", i,
                         (got.size() > gb + i) ? got[gb+i] : 32'hx, 32'h330 + 32'(i));
            end
        end
        repeat (3) step();
    endtask

    task automatic test_simultaneous();
        auto_mem = 1'b0;
        push_req(16'h40);
        push_req(16'h41);
        push_req(16'h42);
        vec++;
        if (o_inflight !== 3'd2) begin errs++;
            $display("FAIL sim_pre: got %0d want 2", o_inflight); end
        man_valid = 1'b1;
        man_data  = 32'hA0;
        step();
        man_data = 32'hA1;
        vec += 3;
        if (o_inflight !== 3'd2) begin errs++;
            $display("FAIL sim_inflight: got %0d want 2", o_inflight); end
        if (o_slave_valid !== 1'b1) begin errs++;
            $display("FAIL sim_sv0: got %b want 1", o_slave_valid); end
        if (o_slave_data !== 32'hA0) begin errs++;
            $display("FAIL sim_d0: got %h want a0", o_slave_data); end
        step();
        man_data = 32'hA2;
        vec += 3;
        if (o_inflight !== 3'd1) begin errs++;
            $display("FAIL sim_inflight1: got %0d want 1", o_inflight); end
        if (o_slave_valid !== 1'b1) begin errs++;
            $display("FAIL sim_sv1: got %b want 1", o_slave_valid); end
        if (o_slave_data !== 32'hA1) begin errs++;
            $display("FAIL sim_d1: got %h want a1", o_slave_data); end
        step();
        man_valid = 1'b0;
        vec += 2;
        if (o_slave_data !== 32'hA2) begin errs++;
            $display("FAIL sim_d2: got %h want a2", o_slave_data); end
        if (o_inflight !== 3'd0) begin errs++;
            $display("FAIL sim_inflight0: got %0d want 0", o_inflight); end
        step();
        step();
        vec++;
        if (o_idle !== 1'b1) begin errs++;
            $display("FAIL sim_idle: got %b want 1", o_idle); end
        auto_mem = 1'b1;
    endtask

    task automatic test_reset_mid();
        int   gb;
        logic ok;
        lat      = 5;
        data_off = 32'h500;
        push_req(16'h50);
        push_req(16'h51);
        push_req(16'h52);
        step();
        vec++;
        if (o_inflight !== 3'd3) begin errs++;
            $display("FAIL rmid_pre: got %0d want 3", o_inflight); end
        #2;
        i_reset_n = 1'b0;
        #1;
        vec += 6;
        if (o_inflight !== 3'd0) begin errs++;
            $display("FAIL rmid_inflight: got %0d want 0", o_inflight); end
        if (o_idle !== 1'b1) begin errs++;
            $display("FAIL rmid_idle: got %b want 1", o_idle); end
        if (o_mem_resp_ready !== 1'b0) begin errs++;
            $display("FAIL rmid_respready: got %b want 0", o_mem_resp_ready); end
        if (o_master_ready !== 1'b1) begin errs++;
            $display("FAIL rmid_mready: got %b want 1", o_master_ready); end
        if (o_mem_req_valid !== 1'b0) begin errs++;
            $display("FAIL rmid_reqvalid: got %b want 0", o_mem_req_valid); end
        if (o_mem_req_addr !== 16'h0) begin errs++;
            $display("FAIL rmid_addr: got %h want 0", o_mem_req_addr); end
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        step();
        vec++;
        if (o_idle !== 1'b1) begin errs++;
            $display("FAIL rmid_idle_rel: got %b want 1", o_idle); end
        gb = got.size();
        lat      = 2;
        data_off = 32'h600;
        push_req(16'h60);
        wait_got(gb + 1, ok);
        vec += 2;
        if (!ok) begin errs++;
            $display("FAIL rmid_timeout: got %0d want 1", got.size() - gb); end
        if (got.size() <= gb || got[gb] !== 32'h660) begin errs++;
            $display("FAIL rmid_data: got %h want 660",
                     (got.size() > gb) ? got[gb] : 32'hx); end
        repeat (3) step();
        vec++;
        if (o_idle !== 1'b1) begin errs++;
            $display("FAIL rmid_idle_end: got %b want 1", o_idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_slave_stall();
        test_mem_stall();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
